axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-granular round-robin arbiter that merges N_SRC AXI-Stream sources onto one AXI-Stream master port. A grant is held from a packet's first beat through its `last` beat, so packets are never interleaved. Each output beat carries the index of the source it came from on `m_id`. The block sits in front of shared stream consumers such as the systolic-array input loader or a DMA write channel, where several producers contend for one stream.

## Interface
Parameters:
- N_SRC, 4: number of source ports, ≥1.
- WORD_W, 8: bits per word.
- BUS_W, 8: bits per beat; must be a multiple of WORD_W.
- WORDS_PER_BEAT, BUS_W/WORD_W: derived, not overridable.
- ID_W, max(1, $clog2(N_SRC)): derived width of `m_id`.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  [N_SRC]  per-source valid.
- s_ready  out  [N_SRC]  per-source ready.
- s_last  in  [N_SRC]  per-source end of packet.
- s_keep  in  [N_SRC][WORDS_PER_BEAT]  per-word keep.
- s_data  in  [N_SRC][WORDS_PER_BEAT][WORD_W]  beat data.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.
- m_last  out  1  end of packet.
- m_keep  out  [WORDS_PER_BEAT]  keep.
- m_data  out  [WORDS_PER_BEAT][WORD_W]  data.
- m_id  out  ID_W  source index of the current output beat.

## Operation
FSM states: IDLE and LOCKED.

IDLE:
- `s_ready` is all zero.
- If any `s_valid` is high, choose the first requester found by searching upward from `rr_ptr`, wrapping modulo N_SRC.
- Register the choice into `grant` and go to LOCKED.
- If no `s_valid` is high, stay in IDLE.

LOCKED:
- `s_ready[grant] = m_ready | ~m_valid`. All other `s_ready` bits are 0.
- A beat is accepted when `s_valid[grant] & s_ready[grant]`. On acceptance, register the beat's data, keep and last into the output stage, register `grant` into `m_id`, and set `m_valid` to 1.
- An accepted beat with `s_last = 1`: set `rr_ptr <= (grant+1) mod N_SRC` and go to IDLE.
- If `s_valid[grant]` drops mid-packet, stay LOCKED and wait. Other sources are never served until the granted source delivers `last`.

Output stage:
- `m_valid` clears on `m_ready & m_valid` when no new beat is accepted in the same cycle.
- If a beat is accepted in the same cycle as the output handshake, the register reloads and `m_valid` stays 1.
- While `m_valid & ~m_ready`, all `m_*` outputs hold stable, as AXIS requires.

Other rules:
- Keep words pass through unchanged. Sparse or zero keep is not checked.
- N_SRC = 1: the arbiter degenerates to a registered pass-through with one idle cycle between packets. `m_id` is 0.
- Single-beat packets (`last` on the first beat) release the grant after that one beat.

## Timing
Reset values (asynchronous, during `rstn = 0`):
- `m_valid = 0`, `m_last = 0`, `m_keep = 0`, `m_data = 0`, `m_id = 0`, `s_ready = 0`.
- State = IDLE, `rr_ptr = 0`, `grant = 0`.

Reset mid-packet: the packet in flight is dropped, with no `last` emitted. After `rstn` rises, arbitration restarts from source 0.

Latency and throughput:
- Arbitration costs 1 cycle: a request seen in IDLE can be accepted at the earliest on the next cycle.
- Source-beat acceptance to `m_valid`: 1 cycle.
- Sustained throughput within a packet is 1 beat/cycle while `m_ready = 1`.
- Between packets there is exactly 1 bubble cycle on the input side (the IDLE arbitration cycle).

Combinational paths:
- `s_ready` depends combinationally on `m_ready`, `m_valid`, state and `grant` only.
- There is no combinational path from any `s_valid` to `s_ready`.

Fairness: under saturated requests, each source gets one packet per N_SRC grants.

## Structure
- Package `axis_arb_pkg` holds:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`
  - a function `rr_pick(req, ptr)` returning the first set index at or after `ptr`, modulo N_SRC.
- One sub-module, `axis_reg_slice`: a single-entry output register with valid/ready, carrying data, keep, last and id. The arbiter FSM, `rr_ptr` and the input mux live in the top.

## Test plan
Every scenario runs with randomized valid/ready probabilities (source 20%, sink 10%), plus one pass at 100%/100%.

- **Single source:** source 2 sends a 5-word packet → exactly 5 output beats, `m_id = 2` throughout, `m_last` only on beat 5, data matches.
- **Saturation, N_SRC = 4:** all sources always valid, 3-beat packets, 8 packets each → grant order 0,1,2,3,0,1,… and no interleaving within a packet.
- **Pointer wrap:** only sources 3 and 1 request → order 1,3,1,3, starting from 1 after reset.
- **Backpressure:** hold `m_ready = 0` for 10 cycles mid-packet → `m_*` stable, `s_ready[grant] = 0`, no beat lost or duplicated.
- **Gapped packet:** granted source drops `s_valid` for 4 cycles mid-packet while source 0 is requesting → source 0 is not granted until the `last` beat.
- **Mid-packet reset:** assert `rstn = 0` on beat 2 of 6 → all outputs go to reset values immediately; the next packet from source 1 is delivered intact with `m_id = 1`.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Purpose: shared types and the round-robin pick helper for axis_rr_arbiter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
// Contents: arb_state_t (IDLE/LOCKED), MAX_SRC bound, rr_pick(req, ptr, n).
package axis_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  // Upper bound on N_SRC; the request vector handed to rr_pick is this wide.
  localparam int MAX_SRC   = 32;
  localparam int MAX_SRC_W = 5;

  // First set bit of req at or after ptr, wrapping modulo n. Offsets are
  // scanned from high to low so the smallest offset is the last to win.
  // With no bit set the result is ptr; callers only use it when |req.
  function automatic int rr_pick(input logic [MAX_SRC-1:0] req,
                                 input int                 ptr,
                                 input int                 n);
    int idx;
    int pick;
    pick = ptr;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (req[idx[MAX_SRC_W-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Purpose: single-entry valid/ready register carrying one packed beat.
// Latency: 1 cycle from input handshake to out_vld.
// Backpressure: in_rdy = out_rdy | ~out_vld; output holds stable while stalled.
// Ports: clk, rstn, in_vld/in_rdy/in_dat (upstream), out_vld/out_rdy/out_dat (downstream).
module axis_reg_slice #(
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_dat
);

  logic             vld_q, vld_d;
  logic [DAT_W-1:0] dat_q, dat_d;

  assign in_rdy  = out_rdy | ~vld_q;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  // A load in the same cycle as the downstream handshake keeps vld set.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Purpose: packet-granular round-robin merge of N_SRC AXI-Stream sources onto one master.
// Latency: 1 arbitration cycle per packet, then 1 cycle from source beat to m_valid.
// Backpressure: only the granted source sees s_ready = m_ready | ~m_valid; others see 0.
// Ports: clk, rstn; s_valid/s_ready/s_last/s_keep/s_data per source;
//        m_valid/m_ready/m_last/m_keep/m_data/m_id on the merged output.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N_SRC          = 4,
  parameter  int WORD_W         = 8,
  parameter  int BUS_W          = 8,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int ID_W           = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic [N_SRC-1:0]                                 s_valid,
  output logic [N_SRC-1:0]                                 s_ready,
  input  logic [N_SRC-1:0]                                 s_last,
  input  logic [N_SRC-1:0][WORDS_PER_BEAT-1:0]             s_keep,
  input  logic [N_SRC-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic                                             m_last,
  output logic [WORDS_PER_BEAT-1:0]                        m_keep,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]            m_data,
  output logic [ID_W-1:0]                                  m_id
);

  typedef struct packed {
    logic                                  last;
    logic [ID_W-1:0]                       id;
    logic [WORDS_PER_BEAT-1:0]             keep;
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data;
  } beat_t;

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [MAX_SRC-1:0] req_ext;
  logic             slot_vld;
  logic             slot_rdy;
  beat_t            slot_dat;
  beat_t            out_beat;

  // Arbitration happens only in IDLE, so s_ready never looks at s_valid;
  // in LOCKED the grant is held until the granted source's last beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_ready  = '0;
    slot_vld = 1'b0;
    req_ext  = '0;
    req_ext[N_SRC-1:0] = s_valid;
    case (state_q)
      IDLE: begin
        if (|s_valid) begin
          grant_d = ID_W'(rr_pick(req_ext, int'(rr_ptr_q), N_SRC));
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        s_ready[grant_q] = slot_rdy;
        slot_vld         = s_valid[grant_q];
        if (slot_vld && slot_rdy && s_last[grant_q]) begin
          rr_ptr_d = ID_W'((int'(grant_q) + 1) % N_SRC);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_dat      = '0;
    slot_dat.last = s_last[grant_q];
    slot_dat.id   = grant_q;
    slot_dat.keep = s_keep[grant_q];
    slot_dat.data = s_data[grant_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  axis_reg_slice #(
    .DAT_W ($bits(beat_t))
  ) u_out_slice (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (slot_vld),
    .in_rdy  (slot_rdy),
    .in_dat  (slot_dat),
    .out_vld (m_valid),
    .out_rdy (m_ready),
    .out_dat (out_beat)
  );

  assign m_last = out_beat.last;
  assign m_id   = out_beat.id;
  assign m_keep = out_beat.keep;
  assign m_data = out_beat.data;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Purpose: self-checking bench for axis_rr_arbiter (N_SRC=4, one 8-bit word per beat).
// Latency: directed per-cycle table, then scoreboarded multi-cycle sequences.
// Backpressure: exercised through random and held-low m_ready.
module tb_axis_rr_arbiter;

  logic                 clk;
  logic                 rstn;
  logic [3:0]           s_valid, s_ready, s_last;
  logic [3:0][0:0]      s_keep;
  logic [3:0][0:0][7:0] s_data;
  logic                 m_valid, m_ready, m_last;
  logic [0:0]           m_keep;
  logic [0:0][7:0]      m_data;
  logic [1:0]           m_id;

  int n_vec  = 0;
  int n_miss = 0;

  axis_rr_arbiter #(.N_SRC(4), .WORD_W(8), .BUS_W(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_keep  (s_keep),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_keep  (m_keep),
    .m_data  (m_data),
    .m_id    (m_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"},  m_last,  0);
    check({tag, "_m_keep"},  m_keep,  0);
    check({tag, "_m_data"},  m_data,  0);
    check({tag, "_m_id"},    m_id,    0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = '0;
    s_last  = '0;
    rstn    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
  endtask

  // ---------------- directed per-cycle table ----------------
  typedef struct {
    logic [3:0] sv;
    logic [3:0] sl;
    logic       mr;
    logic [7:0] d;      // source i drives d + 16*i
    logic [3:0] e_sr;
    logic       e_mv;
    logic [1:0] e_id;
    logic       e_last;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vt[14];

  task automatic drive_table(input logic [3:0] sv, input logic [3:0] sl, input logic mr, input logic [7:0] d);
    s_valid = sv;
    s_last  = sl;
    m_ready = mr;
    for (int i = 0; i < 4; i++) begin
      s_data[i][0] = 8'(d + 8'(i * 16));
      s_keep[i][0] = s_data[i][0][0];
    end
  endtask

  // ---------------- scoreboarded traffic ----------------
  int exp_q[$];
  int plen_g, mr_pct_g, gap_src_g, gap_len_g, gap_cnt_g, hold_at_g;
  int start_cyc[4];
  int left[4], spkt[4], sbeat[4];

  task automatic setup(input logic [3:0] mask, input int npkt, input int plen, input int mr_pct);
    plen_g    = plen;
    mr_pct_g  = mr_pct;
    gap_src_g = -1;
    gap_len_g = 0;
    gap_cnt_g = 0;
    hold_at_g = -1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      left[i]      = mask[i] ? npkt : 0;
      start_cyc[i] = 0;
      spkt[i]      = 0;
      sbeat[i]     = 0;
    end
  endtask

  // Round-robin order from pointer 0 for always-requesting sources.
  task automatic push_rr_order(input logic [3:0] mask, input int npkt);
    for (int p = 0; p < npkt; p++)
      for (int i = 0; i < 4; i++)
        if (mask[i]) exp_q.push_back(i);
  endtask

  task automatic drive_sources(input int cyc);
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = (left[i] > 0) && (cyc >= start_cyc[i]);
      if (i == gap_src_g && sbeat[i] == 1 && gap_cnt_g < gap_len_g) begin
        v = 1'b0;
        gap_cnt_g++;
      end
      s_valid[i]   = v;
      s_last[i]    = (sbeat[i] == plen_g - 1);
      s_data[i][0] = 8'(((i & 3) << 6) | ((spkt[i] & 7) << 3) | (sbeat[i] & 7));
      s_keep[i][0] = s_data[i][0][0];
    end
  endtask

  task automatic run_traffic(input string tag, input int budget);
    int         opkt[4];
    int         obeat, cyc, nbeats, hold_cnt, id;
    logic [3:0] fire;
    logic       mfire, prev_stall;
    logic [11:0] prev_out;
    logic [7:0] edat;
    obeat = 0; cyc = 0; nbeats = 0; hold_cnt = 0; prev_stall = 1'b0; prev_out = '0;
    for (int i = 0; i < 4; i++) opkt[i] = 0;
    m_ready = 1'b1;
    drive_sources(0);
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      fire  = s_valid & s_ready;
      mfire = m_valid & m_ready;
      if (prev_stall) begin
        n_vec++;
        check({tag, "_stall_stable"}, {m_valid, m_last, m_id, m_keep, m_data}, {1'b1, prev_out});
      end
      if (m_valid && !m_ready) begin
        n_vec++;
        check({tag, "_stall_s_ready"}, s_ready, 0);
      end
      if (mfire) begin
        n_vec++;
        id   = exp_q[0];
        edat = 8'(((id & 3) << 6) | ((opkt[id] & 7) << 3) | (obeat & 7));
        check({tag, "_m_id"},   m_id,   id);
        check({tag, "_m_data"}, m_data, edat);
        check({tag, "_m_keep"}, m_keep, edat[0]);
        check({tag, "_m_last"}, m_last, (obeat == plen_g - 1));
        nbeats++;
        if (obeat == plen_g - 1) begin
          void'(exp_q.pop_front());
          opkt[id]++;
          obeat = 0;
        end else begin
          obeat++;
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_out   = {m_last, m_id, m_keep, m_data};
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          if (sbeat[i] == plen_g - 1) begin
            sbeat[i] = 0;
            spkt[i]++;
            left[i]--;
          end else begin
            sbeat[i]++;
          end
        end
      end
      if (hold_at_g >= 0 && nbeats == hold_at_g && hold_cnt < 10) begin
        m_ready = 1'b0;
        hold_cnt++;
      end else begin
        m_ready = ($urandom_range(99) < 32'(mr_pct_g));
      end
      drive_sources(cyc);
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: %0d packets outstanding after %0d cycles, expected 0", tag, exp_q.size(), cyc);
      exp_q.delete();
    end
    s_valid = '0;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      check({tag, "_no_extra_beat"}, m_valid, 0);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_keep  = '0;
    s_data  = '0;
    m_ready = 1'b1;

    //          sv       sl       mr    d       e_sr     mv    id    last  dat
    vt[0]  = '{4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[1]  = '{4'b0100, 4'b0000, 1'b1, 8'h01, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[2]  = '{4'b0100, 4'b0000, 1'b1, 8'h02, 4'b0100, 1'b0, 2'd0, 1'b0, 8'h00};
    vt[3]  = '{4'b0100, 4'b0100, 1'b1, 8'h03, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h22};
    vt[4]  = '{4'b1011, 4'b0000, 1'b0, 8'h04, 4'b0000, 1'b1, 2'd2, 1'b1, 8'h23};
    vt[5]  = '{4'b1011, 4'b1000, 1'b0, 8'h05, 4'b0000, 1'b1, 2'd2, 1'b1, 8'h23};
    vt[6]  = '{4'b1011, 4'b1000, 1'b1, 8'h06, 4'b1000, 1'b1, 2'd2, 1'b1, 8'h23};
    vt[7]  = '{4'b0011, 4'b0011, 1'b1, 8'h07, 4'b0000, 1'b1, 2'd3, 1'b1, 8'h36};
    vt[8]  = '{4'b0011, 4'b0011, 1'b1, 8'h08, 4'b0001, 1'b0, 2'd3, 1'b1, 8'h36};
    vt[9]  = '{4'b0010, 4'b0010, 1'b1, 8'h09, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h08};
    vt[10] = '{4'b0001, 4'b0001, 1'b1, 8'h0A, 4'b0010, 1'b0, 2'd0, 1'b1, 8'h08};
    vt[11] = '{4'b0010, 4'b0010, 1'b1, 8'h0B, 4'b0010, 1'b0, 2'd0, 1'b1, 8'h08};
    vt[12] = '{4'b0000, 4'b0000, 1'b1, 8'h0C, 4'b0000, 1'b1, 2'd1, 1'b1, 8'h1B};
    vt[13] = '{4'b0000, 4'b0000, 1'b1, 8'h0D, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h1B};

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive_table(vt[v].sv, vt[v].sl, vt[v].mr, vt[v].d);
      #2;
      n_vec++;
      check($sformatf("tbl%0d_s_ready", v), s_ready, vt[v].e_sr);
      check($sformatf("tbl%0d_m_valid", v), m_valid, vt[v].e_mv);
      check($sformatf("tbl%0d_m_id", v),    m_id,    vt[v].e_id);
      check($sformatf("tbl%0d_m_last", v),  m_last,  vt[v].e_last);
      check($sformatf("tbl%0d_m_data", v),  m_data,  vt[v].e_dat);
      check($sformatf("tbl%0d_m_keep", v),  m_keep,  vt[v].e_dat[0]);
    end

    // Single source: 5-beat packet from source 2.
    do_reset();
    setup(4'b0100, 1, 5, 100);
    push_rr_order(4'b0100, 1);
    run_traffic("single", 200);

    // Saturation at full rate, then with a random sink.
    do_reset();
    setup(4'b1111, 8, 3, 100);
    push_rr_order(4'b1111, 8);
    run_traffic("sat100", 2000);

    do_reset();
    setup(4'b1111, 8, 3, 90);
    push_rr_order(4'b1111, 8);
    run_traffic("sat90", 4000);

    // Pointer wrap with only sources 1 and 3.
    do_reset();
    setup(4'b1010, 2, 2, 90);
    push_rr_order(4'b1010, 2);
    run_traffic("wrap", 1000);

    // Sink held off for 10 cycles in the middle of a packet.
    do_reset();
    setup(4'b1111, 2, 4, 100);
    hold_at_g = 5;
    push_rr_order(4'b1111, 2);
    run_traffic("bp", 2000);

    // Source 2 granted, then gaps 4 cycles mid-packet while source 0 waits.
    do_reset();
    setup(4'b0101, 1, 3, 100);
    start_cyc[0] = 1;
    gap_src_g    = 2;
    gap_len_g    = 4;
    exp_q.push_back(2);
    exp_q.push_back(0);
    run_traffic("gap", 500);

    // Reset during a 6-beat packet from source 1, then a clean packet.
    do_reset();
    setup(4'b0010, 1, 6, 100);
    drive_sources(0);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    check("midrst_pre_valid", m_valid, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    s_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    setup(4'b0010, 1, 6, 100);
    push_rr_order(4'b0010, 1);
    run_traffic("midrst_after", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
